// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decode operands with write-back bypass,
// detects load-use hazards and supports downstream stall and branch flush.
module id_ex_stage #(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 5,
    parameter int CTRL_WIDTH   = 10,
    parameter int MEM_READ_BIT = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [ADDR_WIDTH-1:0] id_read_addr_1,
    input  logic [ADDR_WIDTH-1:0] id_read_addr_2,
    input  logic [DATA_WIDTH-1:0] id_read_data_1,
    input  logic [DATA_WIDTH-1:0] id_read_data_2,
    input  logic [ADDR_WIDTH-1:0] id_dest_addr,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic [CTRL_WIDTH-1:0] id_ctrl,
    input  logic                  wb_write_enable,
    input  logic [ADDR_WIDTH-1:0] wb_write_addr,
    input  logic [DATA_WIDTH-1:0] wb_write_data,
    output logic                  hazard_stall,
    output logic                  ex_valid,
    output logic [DATA_WIDTH-1:0] ex_op_a,
    output logic [DATA_WIDTH-1:0] ex_op_b,
    output logic [ADDR_WIDTH-1:0] ex_src_addr_1,
    output logic [ADDR_WIDTH-1:0] ex_src_addr_2,
    output logic [ADDR_WIDTH-1:0] ex_dest_addr,
    output logic [DATA_WIDTH-1:0] ex_imm,
    output logic [CTRL_WIDTH-1:0] ex_ctrl
);

    localparam logic [ADDR_WIDTH-1:0] ZR = '1;

    logic                  wb_live;
    logic [DATA_WIDTH-1:0] cap_op_a;
    logic [DATA_WIDTH-1:0] cap_op_b;
    logic                  refresh_a;
    logic                  refresh_b;

    // A write to the zero register never produces visible data.
    assign wb_live = wb_write_enable & (wb_write_addr != ZR);

    assign hazard_stall = ex_valid & ex_ctrl[MEM_READ_BIT] & id_valid &
                          (ex_dest_addr != ZR) &
                          ((ex_dest_addr == id_read_addr_1) |
                           (ex_dest_addr == id_read_addr_2));

    // The register file reads before its same-edge write lands, so the
    // write-back value is forwarded here; the zero register always reads 0.
    always_comb begin
        cap_op_a = id_read_data_1;
        cap_op_b = id_read_data_2;
        if (id_read_addr_1 == ZR) begin
            cap_op_a = '0;
        end else if (wb_live && (wb_write_addr == id_read_addr_1)) begin
            cap_op_a = wb_write_data;
        end
        if (id_read_addr_2 == ZR) begin
            cap_op_b = '0;
        end else if (wb_live && (wb_write_addr == id_read_addr_2)) begin
            cap_op_b = wb_write_data;
        end
    end

    assign refresh_a = ex_valid & wb_live & (wb_write_addr == ex_src_addr_1);
    assign refresh_b = ex_valid & wb_live & (wb_write_addr == ex_src_addr_2);

    always_ff @(posedge clk) begin
        if (reset || flush || (!stall && hazard_stall)) begin
            ex_valid      <= 1'b0;
            ex_op_a       <= '0;
            ex_op_b       <= '0;
            ex_src_addr_1 <= ZR;
            ex_src_addr_2 <= ZR;
            ex_dest_addr  <= ZR;
            ex_imm        <= '0;
            ex_ctrl       <= '0;
        end else if (stall) begin
            // Held instruction must not miss write-backs that retire meanwhile.
            if (refresh_a) begin
                ex_op_a <= wb_write_data;
            end
            if (refresh_b) begin
                ex_op_b <= wb_write_data;
            end
        end else begin
            ex_valid      <= id_valid;
            ex_op_a       <= cap_op_a;
            ex_op_b       <= cap_op_b;
            ex_src_addr_1 <= id_read_addr_1;
            ex_src_addr_2 <= id_read_addr_2;
            ex_dest_addr  <= id_dest_addr;
            ex_imm        <= id_imm;
            ex_ctrl       <= id_ctrl;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, capture, bypass,
// load-use bubble, stall refresh and flush/reset priority.
module tb_id_ex_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [4:0]  id_read_addr_1;
    logic [4:0]  id_read_addr_2;
    logic [63:0] id_read_data_1;
    logic [63:0] id_read_data_2;
    logic [4:0]  id_dest_addr;
    logic [63:0] id_imm;
    logic [9:0]  id_ctrl;
    logic        wb_write_enable;
    logic [4:0]  wb_write_addr;
    logic [63:0] wb_write_data;
    logic        hazard_stall;
    logic        ex_valid;
    logic [63:0] ex_op_a;
    logic [63:0] ex_op_b;
    logic [4:0]  ex_src_addr_1;
    logic [4:0]  ex_src_addr_2;
    logic [4:0]  ex_dest_addr;
    logic [63:0] ex_imm;
    logic [9:0]  ex_ctrl;

    int total = 0;
    int bad   = 0;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid),
        .id_read_addr_1(id_read_addr_1), .id_read_addr_2(id_read_addr_2),
        .id_read_data_1(id_read_data_1), .id_read_data_2(id_read_data_2),
        .id_dest_addr(id_dest_addr), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .wb_write_enable(wb_write_enable), .wb_write_addr(wb_write_addr),
        .wb_write_data(wb_write_data),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid),
        .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
        .ex_src_addr_1(ex_src_addr_1), .ex_src_addr_2(ex_src_addr_2),
        .ex_dest_addr(ex_dest_addr), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_id(input logic v, input logic [4:0] a1, input logic [63:0] d1,
                          input logic [4:0] a2, input logic [63:0] d2,
                          input logic [4:0] dest, input logic [63:0] imm,
                          input logic [9:0] ctrl);
        id_valid       = v;
        id_read_addr_1 = a1;
        id_read_data_1 = d1;
        id_read_addr_2 = a2;
        id_read_data_2 = d2;
        id_dest_addr   = dest;
        id_imm         = imm;
        id_ctrl        = ctrl;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] addr, input logic [63:0] data);
        wb_write_enable = en;
        wb_write_addr   = addr;
        wb_write_data   = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        set_id(1'b1, 5'($urandom_range(0, 30)), {$urandom, $urandom},
               5'($urandom_range(0, 30)), {$urandom, $urandom},
               5'($urandom_range(0, 30)), {$urandom, $urandom}, 10'h3FF);
        set_wb(1'b1, 5'($urandom_range(0, 30)), {$urandom, $urandom});
        tick();
        tick();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ex_valid); end
        total++; if (ex_ctrl !== 10'h000) begin bad++; $display("FAIL reset_ctrl got=%h exp=000", ex_ctrl); end
        total++; if (ex_dest_addr !== 5'd31) begin bad++; $display("FAIL reset_dest got=%0d exp=31", ex_dest_addr); end
        total++; if (ex_src_addr_1 !== 5'd31) begin bad++; $display("FAIL reset_src1 got=%0d exp=31", ex_src_addr_1); end
        total++; if (ex_op_a !== 64'h0) begin bad++; $display("FAIL reset_op_a got=%h exp=0", ex_op_a); end
        total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL reset_hazard got=%b exp=0", hazard_stall); end
        @(negedge clk);
        reset = 1'b0;
        set_wb(1'b0, 5'd0, 64'h0);
    endtask

    task automatic test_capture();
        @(negedge clk);
        set_id(1'b1, 5'd3, 64'h1111, 5'd4, 64'h2222, 5'd8, 64'hFFFF_FFFF_FFFF_FFF0, 10'h2A4);
        tick();
        total++; if (ex_op_a !== 64'h1111) begin bad++; $display("FAIL cap_op_a got=%h exp=1111", ex_op_a); end
        total++; if (ex_op_b !== 64'h2222) begin bad++; $display("FAIL cap_op_b got=%h exp=2222", ex_op_b); end
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL cap_valid got=%b exp=1", ex_valid); end
        total++; if (ex_imm !== 64'hFFFF_FFFF_FFFF_FFF0) begin bad++; $display("FAIL cap_imm got=%h exp=fffffffffffffff0", ex_imm); end
        total++; if (ex_ctrl !== 10'h2A4) begin bad++; $display("FAIL cap_ctrl got=%h exp=2a4", ex_ctrl); end
        total++; if (ex_dest_addr !== 5'd8) begin bad++; $display("FAIL cap_dest got=%0d exp=8", ex_dest_addr); end
        total++; if (ex_src_addr_2 !== 5'd4) begin bad++; $display("FAIL cap_src2 got=%0d exp=4", ex_src_addr_2); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        set_id(1'b1, 5'd3, 64'h1111, 5'd4, 64'h2222, 5'd8, 64'h10, 10'h004);
        set_wb(1'b1, 5'd3, 64'hABCD);
        tick();
        total++; if (ex_op_a !== 64'hABCD) begin bad++; $display("FAIL byp_op_a got=%h exp=abcd", ex_op_a); end
        total++; if (ex_op_b !== 64'h2222) begin bad++; $display("FAIL byp_op_b got=%h exp=2222", ex_op_b); end
        @(negedge clk);
        set_wb(1'b1, 5'd31, 64'hABCD);
        tick();
        total++; if (ex_op_a !== 64'h1111) begin bad++; $display("FAIL byp_zr_wb got=%h exp=1111", ex_op_a); end
        @(negedge clk);
        set_id(1'b1, 5'd31, 64'h1111, 5'd4, 64'h2222, 5'd8, 64'h10, 10'h004);
        set_wb(1'b1, 5'd3, 64'hABCD);
        tick();
        total++; if (ex_op_a !== 64'h0) begin bad++; $display("FAIL byp_zr_src got=%h exp=0", ex_op_a); end
        @(negedge clk);
        set_id(1'b1, 5'd6, 64'h1, 5'd6, 64'h1, 5'd8, 64'h10, 10'h004);
        set_wb(1'b1, 5'd6, 64'hBEEF);
        tick();
        total++; if (ex_op_a !== 64'hBEEF) begin bad++; $display("FAIL byp_same_a got=%h exp=beef", ex_op_a); end
        total++; if (ex_op_b !== 64'hBEEF) begin bad++; $display("FAIL byp_same_b got=%h exp=beef", ex_op_b); end
        @(negedge clk);
        set_wb(1'b0, 5'd0, 64'h0);
    endtask

    task automatic test_load_use();
        @(negedge clk);
        set_id(1'b1, 5'd1, 64'h100, 5'd2, 64'h200, 5'd5, 64'h8, 10'h001);
        tick();
        @(negedge clk);
        set_id(1'b1, 5'd5, 64'h333, 5'd9, 64'h444, 5'd10, 64'h0, 10'h004);
        #1;
        total++; if (hazard_stall !== 1'b1) begin bad++; $display("FAIL lu_hazard got=%b exp=1", hazard_stall); end
        tick();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble_valid got=%b exp=0", ex_valid); end
        total++; if (ex_ctrl !== 10'h000) begin bad++; $display("FAIL lu_bubble_ctrl got=%h exp=000", ex_ctrl); end
        total++; if (ex_dest_addr !== 5'd31) begin bad++; $display("FAIL lu_bubble_dest got=%0d exp=31", ex_dest_addr); end
        total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL lu_hazard_clear got=%b exp=0", hazard_stall); end
        tick();
        total++; if (ex_op_a !== 64'h333) begin bad++; $display("FAIL lu_reissue_op_a got=%h exp=333", ex_op_a); end
        @(negedge clk);
        set_id(1'b1, 5'd1, 64'h100, 5'd2, 64'h200, 5'd31, 64'h8, 10'h001);
        tick();
        @(negedge clk);
        set_id(1'b1, 5'd31, 64'h333, 5'd31, 64'h444, 5'd10, 64'h0, 10'h004);
        #1;
        total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL lu_zr_hazard got=%b exp=0", hazard_stall); end
        tick();
    endtask

    task automatic test_stall_refresh();
        @(negedge clk);
        set_id(1'b1, 5'd2, 64'h77, 5'd7, 64'h99, 5'd9, 64'h123, 10'h0A0);
        tick();
        @(negedge clk);
        stall = 1'b1;
        set_id(1'b1, 5'd12, 64'hDEAD, 5'd13, 64'hBEEF, 5'd14, 64'h999, 10'h3F0);
        tick();
        total++; if (ex_op_b !== 64'h99) begin bad++; $display("FAIL st_hold_op_b got=%h exp=99", ex_op_b); end
        @(negedge clk);
        set_wb(1'b1, 5'd7, 64'h55);
        tick();
        @(negedge clk);
        set_wb(1'b0, 5'd0, 64'h0);
        tick();
        total++; if (ex_op_b !== 64'h55) begin bad++; $display("FAIL st_refresh_op_b got=%h exp=55", ex_op_b); end
        total++; if (ex_op_a !== 64'h77) begin bad++; $display("FAIL st_hold_op_a got=%h exp=77", ex_op_a); end
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL st_valid got=%b exp=1", ex_valid); end
        total++; if (ex_imm !== 64'h123) begin bad++; $display("FAIL st_imm got=%h exp=123", ex_imm); end
        total++; if (ex_ctrl !== 10'h0A0) begin bad++; $display("FAIL st_ctrl got=%h exp=0a0", ex_ctrl); end
        total++; if (ex_dest_addr !== 5'd9) begin bad++; $display("FAIL st_dest got=%0d exp=9", ex_dest_addr); end
        total++; if (ex_src_addr_2 !== 5'd7) begin bad++; $display("FAIL st_src2 got=%0d exp=7", ex_src_addr_2); end
    endtask

    task automatic test_flush_priority();
        @(negedge clk);
        stall = 1'b1;
        flush = 1'b1;
        tick();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL fl_valid got=%b exp=0", ex_valid); end
        total++; if (ex_op_a !== 64'h0) begin bad++; $display("FAIL fl_op_a got=%h exp=0", ex_op_a); end
        total++; if (ex_src_addr_1 !== 5'd31) begin bad++; $display("FAIL fl_src1 got=%0d exp=31", ex_src_addr_1); end
        total++; if (ex_imm !== 64'h0) begin bad++; $display("FAIL fl_imm got=%h exp=0", ex_imm); end
        @(negedge clk);
        stall = 1'b0;
        flush = 1'b0;
        set_id(1'b1, 5'd3, 64'h1234, 5'd4, 64'h5678, 5'd6, 64'h42, 10'h0C0);
        tick();
        total++; if (ex_op_b !== 64'h5678) begin bad++; $display("FAIL fl_recapture got=%h exp=5678", ex_op_b); end
        @(negedge clk);
        reset = 1'b1;
        tick();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b exp=0", ex_valid); end
        total++; if (ex_op_b !== 64'h0) begin bad++; $display("FAIL rst_mid_op_b got=%h exp=0", ex_op_b); end
        total++; if (ex_ctrl !== 10'h000) begin bad++; $display("FAIL rst_mid_ctrl got=%h exp=000", ex_ctrl); end
        total++; if (ex_dest_addr !== 5'd31) begin bad++; $display("FAIL rst_mid_dest got=%0d exp=31", ex_dest_addr); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        set_id(1'b0, 5'd0, 64'h0, 5'd0, 64'h0, 5'd0, 64'h0, 10'h0);
        set_wb(1'b0, 5'd0, 64'h0);
        test_reset();
        test_capture();
        test_bypass();
        test_load_use();
        test_stall_refresh();
        test_flush_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
